// File: rtl/bist_march_seq.sv
// March C- sequencer for the SRAM BIST path: walks six march elements over
// 2^ADDR_W words, drives the SRAM port and records the first miscompare.
module bist_march_seq #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bg_inv,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  output logic              sram_re,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [7:0]        fail_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_RUN_RD, S_RUN_CW, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          elem_q, elem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                bginv_q, bginv_d;
  logic                we_q, we_d, re_q, re_d, busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                fail_q, fail_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]          fail_elem_q, fail_elem_d;
  logic [7:0]          fail_cnt_q, fail_cnt_d;

  logic                down, addr_last, miscmp;
  logic [ADDR_W-1:0]   addr_step;

  function automatic logic [DATA_W-1:0] pat(input logic one, input logic inv);
    return {DATA_W{one ^ inv}};
  endfunction

  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Background each element expects on its read: r1 only in M2 and M4.
  function automatic logic rd_one(input logic [2:0] e);
    return (e == 3'd2) || (e == 3'd4);
  endfunction

  function automatic logic wr_one(input logic [2:0] e);
    return (e == 3'd1) || (e == 3'd3);
  endfunction

  assign down      = is_down(elem_q);
  assign addr_last = down ? (addr_q == '0) : (addr_q == {ADDR_W{1'b1}});
  assign addr_step = down ? (addr_q - 1'b1) : (addr_q + 1'b1);
  assign miscmp    = (state_q == S_RUN_CW) &&
                     (sram_rdata != pat(rd_one(elem_q), bginv_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      bginv_q     <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      bginv_q     <= bginv_d;
      we_q        <= we_d;
      re_q        <= re_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    bginv_d     = bginv_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_cnt_d  = fail_cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          elem_d      = '0;
          addr_d      = '0;
          bginv_d     = bg_inv;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
          fail_cnt_d  = '0;
        end
      end
      S_RUN: begin
        if (addr_last) begin
          state_d = S_RUN_RD;
          elem_d  = 3'd1;
          addr_d  = '0;
        end else begin
          addr_d = addr_step;
        end
      end
      S_RUN_RD: state_d = S_RUN_CW;
      S_RUN_CW: begin
        if (miscmp) begin
          fail_d = 1'b1;
          if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
          if (!fail_q) begin
            fail_addr_d = addr_q;
            fail_elem_d = elem_q;
          end
        end
        // The write of this cycle B is already on the bus, so aborting here keeps it.
        if (miscmp && (STOP_ON_FAIL != 0)) begin
          state_d = S_DONE;
        end else if (addr_last) begin
          if (elem_q == 3'd5) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN_RD;
            elem_d  = elem_q + 3'd1;
            addr_d  = is_down(elem_q + 3'd1) ? {ADDR_W{1'b1}} : '0;
          end
        end else begin
          state_d = S_RUN_RD;
          addr_d  = addr_step;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Port outputs are registered, so they are decoded from the next state.
  always_comb begin
    we_d    = (state_d == S_RUN) || ((state_d == S_RUN_CW) && (elem_d != 3'd5));
    re_d    = (state_d == S_RUN_RD);
    busy_d  = (state_d == S_RUN) || (state_d == S_RUN_RD) || (state_d == S_RUN_CW);
    done_d  = (state_d == S_DONE);
    wdata_d = we_d ? pat(wr_one(elem_d), bginv_d) : '0;
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_we    = we_q;
  assign sram_re    = re_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign fail_addr  = fail_addr_q;
  assign fail_elem  = fail_elem_q;
  assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_bist_march_seq.sv
// Directed bench for bist_march_seq: one run-to-completion and one abort-on-fail
// instance, each on its own behavioural SRAM with an optional stuck-at-0 bit.
module tb_bist_march_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       bg_inv = 1'b0;
  logic       fault_en = 1'b0;

  logic [7:0] addr_a, wdata_a, rdata_a, fail_addr_a, fail_cnt_a;
  logic [7:0] addr_b, wdata_b, rdata_b, fail_addr_b, fail_cnt_b;
  logic       we_a, re_a, busy_a, done_a, fail_a;
  logic       we_b, re_b, busy_b, done_b, fail_b;
  logic [2:0] fail_elem_a, fail_elem_b;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  int checks = 0;
  int errors = 0;
  int ecnt = 0, wcnt = 0, rcnt = 0, excl = 0;
  int e0, wbase, rbase, k, da, db;
  logic busy_2815, done_2815;
  logic [7:0] addr_1280;

  always #5 clk = ~clk;

  bist_march_seq #(.ADDR_W(8), .DATA_W(8), .STOP_ON_FAIL(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .bg_inv(bg_inv),
    .sram_addr(addr_a), .sram_wdata(wdata_a), .sram_we(we_a), .sram_re(re_a),
    .sram_rdata(rdata_a), .busy(busy_a), .done(done_a), .fail(fail_a),
    .fail_addr(fail_addr_a), .fail_elem(fail_elem_a), .fail_cnt(fail_cnt_a)
  );

  bist_march_seq #(.ADDR_W(8), .DATA_W(8), .STOP_ON_FAIL(1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .bg_inv(bg_inv),
    .sram_addr(addr_b), .sram_wdata(wdata_b), .sram_we(we_b), .sram_re(re_b),
    .sram_rdata(rdata_b), .busy(busy_b), .done(done_b), .fail(fail_b),
    .fail_addr(fail_addr_b), .fail_elem(fail_elem_b), .fail_cnt(fail_cnt_b)
  );

  function automatic logic [7:0] fmask(input logic [7:0] a, input logic [7:0] d);
    return (fault_en && a == 8'h5A) ? (d & 8'hF7) : d;
  endfunction

  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= fmask(addr_a, wdata_a);
    if (re_a) rdata_a <= fmask(addr_a, mem_a[addr_a]);
    if (we_b) mem_b[addr_b] <= fmask(addr_b, wdata_b);
    if (re_b) rdata_b <= fmask(addr_b, mem_b[addr_b]);
    ecnt <= ecnt + 1;
    if (we_a) wcnt <= wcnt + 1;
    if (re_a) rcnt <= rcnt + 1;
  end

  always @(negedge clk)
    if ((we_a && re_a) || (we_b && re_b)) excl <= excl + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic inv);
    @(negedge clk);
    bg_inv = inv;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bg_inv = ~inv;
    e0 = ecnt;
    wbase = wcnt;
    rbase = rcnt;
  endtask

  task automatic run(input int limit, input int restart_at, input int rst_at);
    da = -1;
    db = -1;
    for (int i = 0; i < limit; i++) begin
      if (i != 0) @(negedge clk);
      k = ecnt - e0;
      if (k == restart_at) begin start = 1'b1; bg_inv = ~bg_inv; end
      if (k == restart_at + 1) start = 1'b0;
      if (k == 2815) begin busy_2815 = busy_a; done_2815 = done_a; end
      if (k == 1280) addr_1280 = addr_a;
      if (done_a && da < 0) da = k;
      if (done_b && db < 0) db = k;
      if (k == rst_at) begin
        chk("we_before_rst", {31'd0, we_a}, 32'd1);
        rst = 1'b1;
        break;
      end
      if (da >= 0 && db >= 0) break;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, {24'd0, addr_a}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, wdata_a}, 32'd0);
    chk({tag, "_we_re"}, {30'd0, we_a, re_a}, 32'd0);
    chk({tag, "_busy_done"}, {30'd0, busy_a, done_a}, 32'd0);
    chk({tag, "_fail"}, {31'd0, fail_a}, 32'd0);
    chk({tag, "_fail_addr_elem"}, {21'd0, fail_addr_a, fail_elem_a}, 32'd0);
    chk({tag, "_fail_cnt"}, {24'd0, fail_cnt_a}, 32'd0);
    chk({tag, "_b_we_busy"}, {30'd0, we_b, busy_b}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fault-free run, bg_inv=0
    do_start(1'b0);
    chk("t1_busy_op1", {30'd0, busy_a, we_a}, 32'd3);
    run(3000, -10, -10);
    chk("t1_done_edge_a", da, 2816);
    chk("t1_done_edge_b", db, 2816);
    chk("t1_busy_at_2815", {30'd0, busy_2815, done_2815}, 32'd2);
    chk("t1_busy_end", {30'd0, busy_a, busy_b}, 32'd0);
    chk("t1_fail", {22'd0, fail_a, fail_b, fail_cnt_a}, 32'd0);
    chk("t1_writes", wcnt - wbase, 1280);
    chk("t1_reads", rcnt - rbase, 1280);

    // Bit 3 stuck-at-0 at 0x5A, bg_inv=0
    fault_en = 1'b1;
    do_start(1'b0);
    chk("t2_cleared", {29'd0, done_a, fail_a, busy_a}, 32'd1);
    run(3000, -10, -10);
    chk("t2_abort_edge_b", db, 950);
    chk("t2_b_fail", {31'd0, fail_b}, 32'd1);
    chk("t2_b_addr", {24'd0, fail_addr_b}, 32'h5A);
    chk("t2_b_elem", {29'd0, fail_elem_b}, 32'd2);
    chk("t2_b_cnt", {24'd0, fail_cnt_b}, 32'd1);
    chk("t2_b_busy", {31'd0, busy_b}, 32'd0);
    chk("t2_done_edge_a", da, 2816);
    chk("t2_a_fail", {31'd0, fail_a}, 32'd1);
    chk("t2_a_addr", {24'd0, fail_addr_a}, 32'h5A);
    chk("t2_a_elem", {29'd0, fail_elem_a}, 32'd2);
    chk("t2_a_cnt", {24'd0, fail_cnt_a}, 32'd2);

    // Same fault, inverted background
    do_start(1'b1);
    run(3000, -10, -10);
    chk("t3_done_edge_a", da, 2816);
    chk("t3_a_elem", {29'd0, fail_elem_a}, 32'd1);
    chk("t3_a_addr", {24'd0, fail_addr_a}, 32'h5A);
    chk("t3_a_cnt", {24'd0, fail_cnt_a}, 32'd3);
    chk("t3_abort_edge_b", db, 438);
    chk("t3_b_elem", {29'd0, fail_elem_b}, 32'd1);

    // Reset asserted at op 1000, then a clean rerun
    fault_en = 1'b0;
    do_start(1'b0);
    run(3000, -10, 999);
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    do_start(1'b0);
    run(3000, -10, -10);
    chk("t4_done_edge_a", da, 2816);
    chk("t4_fail", {23'd0, fail_a, fail_cnt_a}, 32'd0);

    // Spurious start (with bg_inv toggle) at op 500 is ignored
    do_start(1'b0);
    run(3000, 499, -10);
    chk("t5_done_edge_a", da, 2816);
    chk("t5_done_edge_b", db, 2816);
    chk("t5_m3_first_addr", {24'd0, addr_1280}, 32'hFF);
    chk("t5_fail", {22'd0, fail_a, fail_b, fail_cnt_a}, 32'd0);

    chk("we_re_exclusive", excl, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
